// File: rtl/svm_pkg.sv
// Shared definitions for the sequential one-vs-rest SVM classifier:
// FSM state encoding and the width helpers used to size counters and accumulators.
package svm_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MAC    = 2'd1,
        S_ARGMAX = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Accumulator width: product bits plus sum growth plus sign/bias headroom.
    function automatic int acc_width(input int wa, input int ww, input int nf);
        return wa + ww + clog2(nf) + 2;
    endfunction

    // Bits needed for a counter running 0..n-1 (never narrower than 1).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/svm_mac_lane.sv
// One class accumulator: loads the sign-extended bias, then adds
// zero-extended feature times signed weight once per enabled cycle.
module svm_mac_lane #(
    parameter int WIDTH_A = 4,
    parameter int WIDTH_W = 8,
    parameter int ACC_W   = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    acc_en,
    input  logic [WIDTH_W-1:0]      bias,
    input  logic [WIDTH_A-1:0]      feat,
    input  logic [WIDTH_W-1:0]      weight,
    output logic signed [ACC_W-1:0] acc,
    output logic signed [ACC_W-1:0] sum
);

    // Product width: unsigned feature gains a zero sign bit, times signed weight.
    localparam int PW = WIDTH_A + WIDTH_W + 1;

    logic signed [PW-1:0]    feat_x;
    logic signed [PW-1:0]    weight_x;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;

    assign feat_x   = {{(PW - WIDTH_A){1'b0}}, feat};
    assign weight_x = {{(PW - WIDTH_W){weight[WIDTH_W-1]}}, weight};
    assign prod     = feat_x * weight_x;
    assign prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};
    assign bias_ext = {{(ACC_W - WIDTH_W){bias[WIDTH_W-1]}}, bias};

    // Next value if this cycle accumulates; the top also uses it to seed argmax.
    assign sum = acc + prod_ext;

    // Accumulator register: bias load takes priority over accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (load) begin
            acc <= bias_ext;
        end else if (acc_en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/seq_svm_ovr_classifier.sv
// Time-multiplexed linear one-vs-rest SVM: one feature per cycle into all
// class lanes in parallel, then a one-class-per-cycle argmax.
// Handshake: a vector is taken on a rising edge where in_valid && in_ready;
// a result is released on a rising edge where out_valid && out_ready.
// in_valid is ignored unless idle, out_ready is ignored unless a result is held.
module seq_svm_ovr_classifier
    import svm_pkg::*;
#(
    parameter int NUM_FEAT    = 21,
    parameter int WIDTH_A     = 4,
    parameter int NUM_CLASSES = 3,
    parameter int WIDTH_W     = 8,
    parameter int OUTWIDTH    = 2,
    parameter int ACC_W       = acc_width(WIDTH_A, WIDTH_W, NUM_FEAT)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_FEAT*WIDTH_A-1:0]             inp,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [NUM_CLASSES*NUM_FEAT*WIDTH_W-1:0] coef,
    input  logic [NUM_CLASSES*WIDTH_W-1:0]          bias,
    output logic [OUTWIDTH-1:0]                     out,
    output logic signed [ACC_W-1:0]                 predo,
    output logic                                    out_valid,
    input  logic                                    out_ready
);

    localparam int FC_W = cnt_width(NUM_FEAT);
    localparam logic [FC_W-1:0]     FEAT_LAST = FC_W'(NUM_FEAT - 1);
    localparam logic [OUTWIDTH-1:0] CLS_LAST  = OUTWIDTH'(NUM_CLASSES - 1);

    state_t                       state;
    state_t                       state_nxt;
    logic [NUM_FEAT*WIDTH_A-1:0]  inp_q;
    logic [FC_W-1:0]              feat_cnt;
    logic [OUTWIDTH-1:0]          cls_cnt;
    logic [OUTWIDTH-1:0]          idx;
    logic signed [ACC_W-1:0]      best;
    logic [WIDTH_A-1:0]           feat_cur;
    logic signed [ACC_W-1:0]      acc [NUM_CLASSES];
    logic signed [ACC_W-1:0]      sum [NUM_CLASSES];
    logic                         lane_load;
    logic                         lane_en;
    logic                         better;
    logic signed [ACC_W-1:0]      arg_best;
    logic [OUTWIDTH-1:0]          arg_idx;

    assign feat_cur  = inp_q[int'(feat_cnt)*WIDTH_A +: WIDTH_A];
    assign lane_load = (state == S_IDLE) && in_valid;
    assign lane_en   = (state == S_MAC);

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_lane
        svm_mac_lane #(
            .WIDTH_A (WIDTH_A),
            .WIDTH_W (WIDTH_W),
            .ACC_W   (ACC_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .load   (lane_load),
            .acc_en (lane_en),
            .bias   (bias[c*WIDTH_W +: WIDTH_W]),
            .feat   (feat_cur),
            .weight (coef[(c*NUM_FEAT + int'(feat_cnt))*WIDTH_W +: WIDTH_W]),
            .acc    (acc[c]),
            .sum    (sum[c])
        );
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, in_ready and the argmax candidate (strict > keeps lowest index on ties).
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        better    = (acc[cls_cnt] > best);
        arg_best  = better ? acc[cls_cnt] : best;
        arg_idx   = better ? cls_cnt : idx;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_MAC;
            end
            S_MAC: begin
                if (feat_cnt == FEAT_LAST) state_nxt = S_ARGMAX;
            end
            S_ARGMAX: begin
                if (cls_cnt == CLS_LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: vector capture, feature/class counters, running argmax and result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inp_q     <= '0;
            feat_cnt  <= '0;
            cls_cnt   <= '0;
            idx       <= '0;
            best      <= '0;
            out       <= '0;
            predo     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        inp_q    <= inp;
                        feat_cnt <= '0;
                    end
                end
                S_MAC: begin
                    if (feat_cnt == FEAT_LAST) begin
                        feat_cnt <= '0;
                        best     <= sum[0];
                        idx      <= '0;
                        cls_cnt  <= OUTWIDTH'(1);
                    end else begin
                        feat_cnt <= feat_cnt + 1'b1;
                    end
                end
                S_ARGMAX: begin
                    best    <= arg_best;
                    idx     <= arg_idx;
                    cls_cnt <= cls_cnt + 1'b1;
                    if (cls_cnt == CLS_LAST) begin
                        out       <= arg_idx;
                        predo     <= arg_best;
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_svm_ovr_classifier.sv
// Directed bench for seq_svm_ovr_classifier with 3 features, 3 classes,
// 4-bit features and weights. Inputs change on falling edges, outputs are
// sampled on falling edges.
module tb_seq_svm_ovr_classifier;

    localparam int NF = 3;
    localparam int NC = 3;
    localparam int WA = 4;
    localparam int WW = 4;
    localparam int OW = 2;
    localparam int AW = 12;  // 4 + 4 + clog2(3) + 2

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NF*WA-1:0]    inp = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [NC*NF*WW-1:0] coef = '0;
    logic [NC*WW-1:0]    bias = '0;
    logic [OW-1:0]       out;
    logic signed [AW-1:0] predo;
    logic                out_valid;
    logic                out_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    seq_svm_ovr_classifier #(
        .NUM_FEAT    (NF),
        .WIDTH_A     (WA),
        .NUM_CLASSES (NC),
        .WIDTH_W     (WW),
        .OUTWIDTH    (OW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inp       (inp),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coef      (coef),
        .bias      (bias),
        .out       (out),
        .predo     (predo),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Clock.
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------

    // Identity weights w_c = e_c, biases (0,0,-2).
    task automatic set_identity();
        coef = '0;
        for (int c = 0; c < NC; c++) begin
            coef[(c*NF + c)*WW +: WW] = 4'd1;
        end
        bias = {4'hE, 4'h0, 4'h0};
    endtask

    // Pack three features, feature 0 in the low nibble.
    function automatic logic [NF*WA-1:0] vec(input int f0, input int f1, input int f2);
        logic [WA-1:0] a0, a1, a2;
        a0 = WA'(f0);
        a1 = WA'(f1);
        a2 = WA'(f2);
        return {a2, a1, a0};
    endfunction

    // Present a vector for one rising edge; returns at the falling edge after it.
    task automatic accept_vec(input logic [NF*WA-1:0] v);
        @(negedge clk);
        inp      = v;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        inp      = '0;
    endtask

    // Wait for out_valid, counting rising edges; bounded.
    task automatic wait_out(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        n_cmp++;
        if (out !== 2'd0 || predo !== 12'sd0) begin
            n_bad++;
            $display("FAIL reset_outputs: out=%0d predo=%0d, required 0 0", out, predo);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Generic single-vector check with out_ready held high.
    task automatic run_one(input string name, input logic [NF*WA-1:0] v,
                           input logic [OW-1:0] exp_out, input logic signed [AW-1:0] exp_predo,
                           input bit check_lat);
        int cyc;
        bit ok;
        out_ready = 1'b1;
        accept_vec(v);
        wait_out(cyc, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s_timeout: out_valid never rose within %0d cycles", name, cyc);
            return;
        end
        if (check_lat) begin
            n_cmp++;
            if (cyc != 5) begin
                n_bad++;
                $display("FAIL %s_latency: %0d cycles after accept, required 5", name, cyc);
            end
        end
        n_cmp++;
        if (out !== exp_out || predo !== exp_predo) begin
            n_bad++;
            $display("FAIL %s_result: out=%0d predo=%0d, required out=%0d predo=%0d",
                     name, out, predo, exp_out, exp_predo);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b, required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_basic();
        set_identity();
        run_one("basic", vec(2, 9, 4), 2'd1, 12'sd9, 1'b1);
    endtask

    task automatic test_tie();
        set_identity();
        run_one("tie", vec(5, 3, 7), 2'd0, 12'sd5, 1'b1);
    endtask

    task automatic test_extreme();
        for (int i = 0; i < NC*NF; i++) begin
            coef[i*WW +: WW] = 4'h8;  // -8
        end
        bias = {4'h0, 4'h8, 4'h7};    // (7, -8, 0)
        run_one("extreme", vec(15, 15, 15), 2'd0, -12'sd353, 1'b1);
        set_identity();
    endtask

    task automatic test_backpressure();
        int cyc;
        bit ok;
        set_identity();
        out_ready = 1'b0;
        accept_vec(vec(2, 9, 4));
        wait_out(cyc, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL bp_timeout: out_valid never rose within %0d cycles", cyc);
            return;
        end
        inp      = vec(0, 0, 15);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== 2'd1 || predo !== 12'sd9) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b out=%0d predo=%0d, required 1 0 1 9",
                         i, out_valid, in_ready, out, predo);
            end
        end
        in_valid  = 1'b0;
        inp       = '0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        // No vector was queued during the stall.
        repeat (8) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_no_second_accept: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        set_identity();
        out_ready = 1'b1;
        accept_vec(vec(9, 9, 9));
        @(posedge clk);   // first MAC edge: feat_cnt now 1
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_busy: in_ready=%b, required 0", in_ready);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_async: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL rmid_no_result: out_valid=1 seen after reset, required 0");
        end
        run_one("rmid_next", vec(0, 0, 15), 2'd2, 12'sd13, 1'b1);
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit ok;
        set_identity();
        out_ready = 1'b1;
        accept_vec(vec(1, 2, 3));
        wait_out(cyc, ok);
        n_cmp++;
        if (!ok || out !== 2'd1 || predo !== 12'sd2) begin
            n_bad++;
            $display("FAIL b2b_first: ok=%b out=%0d predo=%0d, required 1 1 2", ok, out, predo);
        end
        // Second vector offered continuously from the cycle the first result shows.
        inp      = vec(6, 1, 9);
        in_valid = 1'b1;
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 2) in_valid = 1'b0;  // taken on the edge after release
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (!ok || cyc != 7) begin
            n_bad++;
            $display("FAIL b2b_spacing: ok=%b %0d cycles between results, required 7", ok, cyc);
        end
        n_cmp++;
        if (out !== 2'd2 || predo !== 12'sd7) begin
            n_bad++;
            $display("FAIL b2b_second: out=%0d predo=%0d, required 2 7", out, predo);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        set_identity();
        test_reset();
        test_basic();
        test_tie();
        test_extreme();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
